store_buffer: RTL and testbench

- Write-posting FIFO between the store unit and the data cache / external memory port.
- Accepts committed stores at one per cycle and drains them in order through a request/acknowledge handshake.
- Provides store-to-load address matching and word forwarding to the load path, so loads never read stale cache data.
- Its full, idle and match outputs drive the data cache's store_buffer_full_i, store_buffer_port_idle_i, store_buffer_address_match_i and store_buffer_data_i inputs.

---
 rtl/store_buffer.sv | 132 +++++++++++++
 tb/tb_store_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Write-posting store FIFO draining in order to memory over a request/acknowledge
// handshake, with youngest-match store-to-load forwarding on the word address.
module store_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] push_address_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [1:0]            push_width_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  port_idle_o,
  input  logic [ADDR_WIDTH-1:0] load_address_i,
  output logic                  address_match_o,
  output logic                  forward_valid_o,
  output logic [DATA_WIDTH-1:0] forward_data_o,
  output logic                  mem_request_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [1:0]            mem_width_o,
  input  logic                  mem_acknowledge_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [1:0]            width_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [PTR_W:0]        count_q;

  logic push_ok;
  logic pop;
  logic [1:0] load_offset_unused;

  assign load_offset_unused = load_address_i[1:0];

  assign full_o      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign port_idle_o = empty_o && (state_q == IDLE);
  assign push_ok     = push_i && !full_o;
  assign pop         = (state_q == WAIT_ACK) && mem_acknowledge_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        width_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        addr_q[tail_q]  <= push_address_i;
        data_q[tail_q]  <= push_data_i;
        width_q[tail_q] <= push_width_i;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      // head and tail slots never coincide here: pop needs count>0, push needs count<DEPTH
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      mem_request_o <= 1'b0;
      mem_address_o <= '0;
      mem_data_o    <= '0;
      mem_width_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            mem_address_o <= addr_q[head_q];
            mem_data_o    <= data_q[head_q];
            mem_width_o   <= width_q[head_q];
            mem_request_o <= 1'b1;
            state_q       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (mem_acknowledge_i) begin
            mem_request_o <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Walk oldest to youngest so the last hit (youngest) overrides earlier ones.
  always_comb begin
    address_match_o = 1'b0;
    forward_valid_o = 1'b0;
    forward_data_o  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] &&
          (addr_q[idx][ADDR_WIDTH-1:2] == load_address_i[ADDR_WIDTH-1:2])) begin
        address_match_o = 1'b1;
        forward_data_o  = data_q[idx];
        forward_valid_o = (width_q[idx] == WIDTH_WORD);
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// against a queue-based reference model of the FIFO, drain handshake and forwarding.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        push_i;
  logic [31:0] push_address_i;
  logic [31:0] push_data_i;
  logic [1:0]  push_width_i;
  logic        full_o, empty_o, port_idle_o;
  logic [31:0] load_address_i;
  logic        address_match_o, forward_valid_o;
  logic [31:0] forward_data_o;
  logic        mem_request_o;
  logic [31:0] mem_address_o, mem_data_o;
  logic [1:0]  mem_width_o;
  logic        mem_acknowledge_i;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .push_i(push_i), .push_address_i(push_address_i), .push_data_i(push_data_i),
    .push_width_i(push_width_i),
    .full_o(full_o), .empty_o(empty_o), .port_idle_o(port_idle_o),
    .load_address_i(load_address_i),
    .address_match_o(address_match_o), .forward_valid_o(forward_valid_o),
    .forward_data_o(forward_data_o),
    .mem_request_o(mem_request_o), .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o), .mem_width_o(mem_width_o),
    .mem_acknowledge_i(mem_acknowledge_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  w;
  } ent_t;

  ent_t        q[$];
  logic [31:0] popped[$];
  bit          req_m;
  ent_t        req_e;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit          hit = 0;
    ent_t        e;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a[31:2] == load_address_i[31:2]) begin
        hit = 1;
        e = q[i];
        break;
      end
    end
    chk("full", {31'd0, full_o}, {31'd0, q.size() == DEPTH});
    chk("empty", {31'd0, empty_o}, {31'd0, q.size() == 0});
    chk("port_idle", {31'd0, port_idle_o}, {31'd0, q.size() == 0 && !req_m});
    chk("mem_request", {31'd0, mem_request_o}, {31'd0, req_m});
    if (req_m) begin
      chk("mem_address", mem_address_o, req_e.a);
      chk("mem_data", mem_data_o, req_e.d);
      chk("mem_width", {30'd0, mem_width_o}, {30'd0, req_e.w});
    end
    chk("address_match", {31'd0, address_match_o}, {31'd0, hit});
    chk("forward_valid", {31'd0, forward_valid_o}, {31'd0, hit && e.w == 2'd2});
    chk("forward_data", forward_data_o, hit ? e.d : 32'd0);
  endtask

  // One clock: check outputs mid-cycle, clock, then advance the model.
  task automatic cycle(input bit p, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w, input bit ack);
    int   sz;
    bit   do_pop, do_push, new_req;
    ent_t ne;
    push_i = p; push_address_i = a; push_data_i = d; push_width_i = w;
    mem_acknowledge_i = ack;
    #3;
    check_model();
    @(posedge clk_i);
    sz      = q.size();
    do_pop  = req_m && ack;
    do_push = p && (sz < DEPTH);
    new_req = req_m ? !do_pop : (sz != 0);
    if (!req_m && sz != 0) req_e = q[0];
    if (do_pop) begin
      popped.push_back(q[0].a);
      void'(q.pop_front());
    end
    if (do_push) begin
      ne.a = a; ne.d = d; ne.w = w;
      q.push_back(ne);
    end
    req_m = new_req;
    #1;
    push_i = 0;
    mem_acknowledge_i = 0;
  endtask

  task automatic idle_cycle();
    cycle(0, 32'd0, 32'd0, 2'd0, 0);
  endtask

  task automatic drain_one(input int lat);
    int k = 0;
    while (!mem_request_o && k < 20) begin
      idle_cycle();
      k++;
    end
    if (!mem_request_o) chk("request_timeout", 32'd0, 32'd1);
    for (int j = 1; j < lat; j++) idle_cycle();
    cycle(0, 32'd0, 32'd0, 2'd0, 1);
  endtask

  initial begin
    logic [31:0] exp_order [4];
    exp_order[0] = 32'h100; exp_order[1] = 32'h104;
    exp_order[2] = 32'h108; exp_order[3] = 32'h10C;

    rst_n_i = 0; push_i = 0; push_address_i = 0; push_data_i = 0; push_width_i = 0;
    load_address_i = 32'h100; mem_acknowledge_i = 0;
    req_m = 0; req_e = '0;
    #12;
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_port_idle", {31'd0, port_idle_o}, 32'd1);
    chk("rst_mem_request", {31'd0, mem_request_o}, 32'd0);
    chk("rst_mem_address", mem_address_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_match", {31'd0, address_match_o}, 32'd0);
    chk("rst_forward_data", forward_data_o, 32'd0);
    #2 rst_n_i = 1;
    @(posedge clk_i); #1;

    // Fill to full; fifth push must be dropped.
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h100 + 32'(i * 4), 32'hD000_0000 + 32'(i), 2'd2, 0);
    chk("full_after_4", {31'd0, full_o}, 32'd1);
    chk("first_req_addr", mem_address_o, 32'h100);
    cycle(1, 32'h200, 32'hDEAD_BEEF, 2'd2, 0);
    chk("push_when_full_ignored", 32'(q.size()), 32'd4);

    popped.delete();
    for (int i = 0; i < 4; i++) drain_one(3);
    idle_cycle();
    chk("drain_count", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("drain_order", popped[i], exp_order[i]);
    chk("empty_after_drain", {31'd0, empty_o}, 32'd1);
    chk("idle_after_drain", {31'd0, port_idle_o}, 32'd1);

    // Youngest WORD match forwards.
    load_address_i = 32'h42;
    cycle(1, 32'h40, 32'hAAAA_0000, 2'd2, 0);
    cycle(1, 32'h40, 32'hBBBB_1111, 2'd2, 0);
    #1;
    chk("fwd_match", {31'd0, address_match_o}, 32'd1);
    chk("fwd_valid", {31'd0, forward_valid_o}, 32'd1);
    chk("fwd_data", forward_data_o, 32'hBBBB_1111);
    drain_one(1); drain_one(2);
    idle_cycle();

    // BYTE match must stall the load (no forward) until drained.
    load_address_i = 32'h80;
    cycle(1, 32'h81, 32'h7F, 2'd0, 0);
    #1;
    chk("byte_match", {31'd0, address_match_o}, 32'd1);
    chk("byte_no_forward", {31'd0, forward_valid_o}, 32'd0);
    drain_one(2);
    idle_cycle();
    chk("byte_match_gone", {31'd0, address_match_o}, 32'd0);

    // Ack and push together while full: push dropped, count falls to 3.
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h300 + 32'(i * 4), 32'h3000 + 32'(i), 2'd2, 0);
    cycle(1, 32'h3F0, 32'h3FFF, 2'd2, 1);
    chk("ack_push_full_count", 32'(q.size()), 32'd3);
    chk("ack_push_full_flag", {31'd0, full_o}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 32'h500 + 32'(i * 4), 32'h5000 + 32'(i), 2'd2, 0);
      drain_one(1);
    end

    // Random traffic with word-address aliasing.
    for (int i = 0; i < 400; i++) begin
      load_address_i = 32'h40 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 1) == 1,
            32'h40 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)),
            $urandom, 2'($urandom_range(0, 2)),
            $urandom_range(0, 9) < 3);
    end
    for (int i = 0; i < 8 && q.size() != 0; i++) drain_one(1);

    // Asynchronous reset during an outstanding request with 2 entries.
    cycle(1, 32'h600, 32'h6666, 2'd2, 0);
    cycle(1, 32'h604, 32'h7777, 2'd2, 0);
    chk("pre_reset_req", {31'd0, mem_request_o}, 32'd1);
    #2 rst_n_i = 0;
    #1;
    chk("async_rst_req", {31'd0, mem_request_o}, 32'd0);
    chk("async_rst_empty", {31'd0, empty_o}, 32'd1);
    chk("async_rst_idle", {31'd0, port_idle_o}, 32'd1);
    q.delete();
    req_m = 0;
    #3 rst_n_i = 1;
    @(posedge clk_i); #1;
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
